md_unit: RTL and testbench

- E-stage multiply/divide unit for the P6 pipelined MIPS core.
- It is the producer of HI/LO. It executes mult/multu/div/divu over several cycles and applies mthi/mtlo writes.
- It serves mfhi/mflo reads through a read port that E-stage results flow through toward W.
- External hazard logic stalls D using Start|Busy.

---
 rtl/md_unit.sv | 162 ++++++++++++++++
 tb/tb_md_unit.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/md_unit.sv
// HI/LO multiply/divide unit for the E stage: multi-cycle mult/multu/div/divu, mthi/mtlo writes.
// Optional MDU_CANCEL_EN adds a Cancel input that aborts an operation in flight.
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [2:0]  MDOp,
  input  logic        Start,
  input  logic        RdSel,
`ifdef MDU_CANCEL_EN
  input  logic        Cancel,
`endif
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] MDOut
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(1);

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6,
    OP_RSVD  = 3'd7
  } md_op_e;

  // Both operands are widened to 66 bits so one signed multiplier serves mult and multu.
  function automatic logic [63:0] mul_result(input logic [31:0] a, input logic [31:0] b,
                                             input logic sgn);
    logic signed [65:0] sa;
    logic signed [65:0] sb;
    logic signed [65:0] p;
    sa = {{34{sgn & a[31]}}, a};
    sb = {{34{sgn & b[31]}}, b};
    p  = sa * sb;
    return p[63:0];
  endfunction

  // Signed divide runs on magnitudes; 0x80000000 / -1 wraps back to 0x80000000 naturally.
  function automatic logic [63:0] div_result(input logic [31:0] a, input logic [31:0] b,
                                             input logic sgn);
    logic [31:0] ma;
    logic [31:0] mb;
    logic [31:0] uq;
    logic [31:0] ur;
    logic        neg_a;
    logic        neg_b;
    neg_a = sgn & a[31];
    neg_b = sgn & b[31];
    ma    = neg_a ? (~a + 32'd1) : a;
    mb    = neg_b ? (~b + 32'd1) : b;
    if (mb == 32'd0) mb = 32'd1;
    uq = ma / mb;
    ur = ma % mb;
    return {(neg_a ? (~ur + 32'd1) : ur), ((neg_a ^ neg_b) ? (~uq + 32'd1) : uq)};
  endfunction

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;
  logic             pend_q, pend_d;
  logic [31:0]      rhi_q, rlo_q;
  logic             load_en;
  logic             cancel_w;
  logic [63:0]      res_w;
  md_op_e           op;

`ifdef MDU_CANCEL_EN
  assign cancel_w = Cancel;
`else
  assign cancel_w = 1'b0;
`endif

  assign op = md_op_e'(MDOp);

  always_comb begin
    res_w = 64'd0;
    if (op == OP_DIV || op == OP_DIVU) res_w = div_result(A, B, op == OP_DIV);
    else                               res_w = mul_result(A, B, op == OP_MULT);
  end

  always_comb begin
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    pend_d  = pend_q;
    load_en = 1'b0;
    if (cnt_q != '0) begin
      if (cancel_w) begin
        cnt_d  = '0;
        pend_d = 1'b0;
      end else if (cnt_q == CNT_LAST) begin
        cnt_d  = '0;
        pend_d = 1'b0;
        if (pend_q) begin
          hi_d = rhi_q;
          lo_d = rlo_q;
        end
      end else begin
        cnt_d = cnt_q - CNT_LAST;
      end
    end else if (Start && !cancel_w) begin
      case (op)
        OP_MULT, OP_MULTU: begin
          load_en = 1'b1;
          cnt_d   = MULT_LOAD;
          pend_d  = 1'b1;
        end
        OP_DIV, OP_DIVU: begin
          load_en = 1'b1;
          cnt_d   = DIV_LOAD;
          pend_d  = (B != 32'd0);
        end
        OP_MTHI: hi_d = A;
        OP_MTLO: lo_d = A;
        default: ;
      endcase
    end
  end

  // Architectural state and control
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      hi_q   <= 32'd0;
      lo_q   <= 32'd0;
      pend_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      pend_q <= pend_d;
    end
  end

  // Shadow result, committed only when pend_q survives to the final cycle
  always_ff @(posedge clk) begin
    if (load_en) begin
      rhi_q <= res_w[63:32];
      rlo_q <= res_w[31:0];
    end
  end

  assign Busy  = (cnt_q != '0);
  assign HI    = hi_q;
  assign LO    = lo_q;
  assign MDOut = RdSel ? hi_q : lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Scoreboard bench for md_unit: expected HI/LO queued at launch, popped when Busy falls.
module tb_md_unit;
  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] A, B;
  logic [2:0]  MDOp;
  logic        Start;
  logic        RdSel;
  logic        Cancel;
  logic        Busy;
  logic [31:0] HI, LO, MDOut;

  always #5 clk = ~clk;

  md_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .A(A), .B(B), .MDOp(MDOp), .Start(Start), .RdSel(RdSel),
`ifdef MDU_CANCEL_EN
    .Cancel(Cancel),
`endif
    .Busy(Busy), .HI(HI), .LO(LO), .MDOut(MDOut)
  );

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } hl_t;

  hl_t         sb_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  function automatic logic [63:0] model_md(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b, input logic [63:0] cur);
    logic signed [63:0] sa, sb, q, r;
    logic [63:0] res;
    res = cur;
    sa  = {{32{a[31]}}, a};
    sb  = {{32{b[31]}}, b};
    case (op)
      3'd1: res = sa * sb;
      3'd2: res = {32'd0, a} * {32'd0, b};
      3'd3: if (b != 32'd0) begin
        q   = sa / sb;
        r   = sa % sb;
        res = {r[31:0], q[31:0]};
      end
      3'd4: if (b != 32'd0) res = {a % b, a / b};
      default: ;
    endcase
    return res;
  endfunction

  // Called at a negedge; leaves after one clock edge with Start released.
  task automatic launch(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] expv);
    hl_t e;
    Start = 1'b1; MDOp = op; A = a; B = b;
    e.hi = expv[63:32]; e.lo = expv[31:0];
    sb_q.push_back(e);
    @(negedge clk);
    Start = 1'b0; MDOp = 3'd0;
  endtask

  // Counts Busy cycles (bounded) and whether MDOut held the old LO meanwhile.
  task automatic wait_idle(output int cycles, output bit held);
    cycles = 0; held = 1'b1;
    while (Busy === 1'b1 && cycles < 100) begin
      if (MDOut !== m_lo) held = 1'b0;
      cycles++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; Start = 1'b0; MDOp = 3'd0; A = 32'd0; B = 32'd0; RdSel = 1'b0; Cancel = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    n_tests++; if (HI !== 32'd0) begin n_fail++; $display("FAIL reset_hi: got %h, expected 0", HI); end
    n_tests++; if (LO !== 32'd0) begin n_fail++; $display("FAIL reset_lo: got %h, expected 0", LO); end
    n_tests++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, expected 0", Busy); end
    n_tests++; if (MDOut !== 32'd0) begin n_fail++; $display("FAIL reset_mdout: got %h, expected 0", MDOut); end
  endtask

  task automatic run_table(input string tag, input logic [2:0] ops[], input logic [31:0] as[],
                           input logic [31:0] bs[], input logic [63:0] exps[], input int ncyc);
    int c; bit h; hl_t e; logic [63:0] ev;
    for (int i = 0; i < ops.size(); i++) begin
      ev = exps[i];
      launch(ops[i], as[i], bs[i], ev);
      wait_idle(c, h);
      e = sb_q.pop_front();
      n_tests++; if (c != ncyc) begin n_fail++; $display("FAIL %s[%0d]_busy_cycles: got %0d, expected %0d", tag, i, c, ncyc); end
      n_tests++; if (!h) begin n_fail++; $display("FAIL %s[%0d]_mdout_old_lo: MDOut left old LO %h", tag, i, m_lo); end
      n_tests++; if (HI !== e.hi) begin n_fail++; $display("FAIL %s[%0d]_hi: got %h, expected %h", tag, i, HI, e.hi); end
      n_tests++; if (LO !== e.lo) begin n_fail++; $display("FAIL %s[%0d]_lo: got %h, expected %h", tag, i, LO, e.lo); end
      m_hi = e.hi; m_lo = e.lo;
    end
  endtask

  task automatic test_mult;
    logic [2:0] ops[]; logic [31:0] as[], bs[]; logic [63:0] ex[];
    ops = new[4]; as = new[4]; bs = new[4]; ex = new[4];
    ops[0] = 3'd1; as[0] = 32'hFFFFFFFF; bs[0] = 32'd2; ex[0] = 64'hFFFFFFFF_FFFFFFFE;
    ops[1] = 3'd2; as[1] = 32'hFFFFFFFF; bs[1] = 32'd2; ex[1] = 64'h00000001_FFFFFFFE;
    ops[2] = 3'd1; as[2] = $urandom; bs[2] = $urandom | 32'h80000000;
    ops[3] = 3'd2; as[3] = $urandom; bs[3] = $urandom;
    ex[2] = model_md(3'd1, as[2], bs[2], 64'd0);
    ex[3] = model_md(3'd2, as[3], bs[3], 64'd0);
    run_table("mult", ops, as, bs, ex, MC);
  endtask

  task automatic test_div;
    logic [2:0] ops[]; logic [31:0] as[], bs[]; logic [63:0] ex[];
    ops = new[2]; as = new[2]; bs = new[2]; ex = new[2];
    ops[0] = 3'd3; as[0] = 32'hFFFFFFF9; bs[0] = 32'd2;          ex[0] = 64'hFFFFFFFF_FFFFFFFD;
    ops[1] = 3'd3; as[1] = 32'h80000000; bs[1] = 32'hFFFFFFFF;   ex[1] = 64'h00000000_80000000;
    run_table("div", ops, as, bs, ex, DC);
    // divide by zero must leave HI/LO at their prior values; then model-checked randoms
    ops = new[3]; as = new[3]; bs = new[3]; ex = new[3];
    ops[0] = 3'd4; as[0] = 32'd7; bs[0] = 32'd0; ex[0] = {m_hi, m_lo};
    ops[1] = 3'd3; as[1] = $urandom | 32'h80000000; bs[1] = $urandom_range(1, 999);
    ops[2] = 3'd4; as[2] = $urandom; bs[2] = $urandom_range(1, 65535);
    ex[1] = model_md(3'd3, as[1], bs[1], ex[0]);
    ex[2] = model_md(3'd4, as[2], bs[2], ex[1]);
    run_table("divz", ops, as, bs, ex, DC);
  endtask

  task automatic test_mthi_mtlo;
    Start = 1'b1; MDOp = 3'd5; A = 32'h12345678;
    @(negedge clk); Start = 1'b0; MDOp = 3'd0;
    n_tests++; if (HI !== 32'h12345678) begin n_fail++; $display("FAIL mthi_hi: got %h, expected 12345678", HI); end
    n_tests++; if (LO !== m_lo) begin n_fail++; $display("FAIL mthi_lo: got %h, expected %h", LO, m_lo); end
    n_tests++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL mthi_busy: got %b, expected 0", Busy); end
    m_hi = 32'h12345678;
    Start = 1'b1; MDOp = 3'd6; A = 32'h0000CAFE;
    @(negedge clk); Start = 1'b0; MDOp = 3'd0;
    n_tests++; if (LO !== 32'h0000CAFE) begin n_fail++; $display("FAIL mtlo_lo: got %h, expected 0000cafe", LO); end
    m_lo = 32'h0000CAFE;
    RdSel = 1'b1;
    #1;
    n_tests++; if (MDOut !== m_hi) begin n_fail++; $display("FAIL mdout_hi_sel: got %h, expected %h", MDOut, m_hi); end
    RdSel = 1'b0;
    // MDOp 0 and 7 are no-ops; Start=0 ignores MDOp
    Start = 1'b1; MDOp = 3'd7; A = 32'hDEADBEEF; B = 32'd3;
    @(negedge clk); MDOp = 3'd0;
    @(negedge clk); Start = 1'b0; MDOp = 3'd5;
    @(negedge clk); MDOp = 3'd0;
    n_tests++; if ({Busy, HI, LO} !== {1'b0, m_hi, m_lo}) begin n_fail++;
      $display("FAIL noop_ops: got busy=%b hi=%h lo=%h, expected busy=0 hi=%h lo=%h", Busy, HI, LO, m_hi, m_lo); end
  endtask

  task automatic test_ignore_while_busy;
    int c; bit h; hl_t e;
    launch(3'd1, 32'd3, 32'd4, 64'd12);
    @(negedge clk);
    Start = 1'b1; MDOp = 3'd6; A = 32'h0000AAAA;
    @(negedge clk); Start = 1'b0; MDOp = 3'd0;
    wait_idle(c, h);
    e = sb_q.pop_front();
    n_tests++; if (c + 2 != MC) begin n_fail++; $display("FAIL busy_ign_cycles: got %0d, expected %0d", c + 2, MC); end
    n_tests++; if (!h) begin n_fail++; $display("FAIL busy_ign_mdout: MDOut left old LO %h", m_lo); end
    n_tests++; if (LO !== e.lo) begin n_fail++; $display("FAIL busy_ign_lo: got %h, expected %h", LO, e.lo); end
    n_tests++; if (HI !== e.hi) begin n_fail++; $display("FAIL busy_ign_hi: got %h, expected %h", HI, e.hi); end
    m_hi = e.hi; m_lo = e.lo;
  endtask

  task automatic test_back_to_back;
    int c; bit h; hl_t e;
    // second op launched the very first cycle Busy is low
    launch(3'd2, 32'h00010000, 32'h00010000, 64'h00000001_00000000);
    wait_idle(c, h); e = sb_q.pop_front(); m_hi = e.hi; m_lo = e.lo;
    launch(3'd4, 32'd100, 32'd7, model_md(3'd4, 32'd100, 32'd7, {m_hi, m_lo}));
    wait_idle(c, h); e = sb_q.pop_front();
    n_tests++; if ({HI, LO} !== {e.hi, e.lo} || c != DC) begin n_fail++;
      $display("FAIL b2b_divu: got hi=%h lo=%h cyc=%0d, expected hi=%h lo=%h cyc=%0d", HI, LO, c, e.hi, e.lo, DC); end
    m_hi = e.hi; m_lo = e.lo;
  endtask

  task automatic test_reset_mid;
    launch(3'd1, 32'd7, 32'd9, 64'd63);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    void'(sb_q.pop_front());
    n_tests++; if ({Busy, HI, LO} !== 65'd0) begin n_fail++;
      $display("FAIL reset_mid: got busy=%b hi=%h lo=%h, expected all 0", Busy, HI, LO); end
    repeat (MC + 2) @(negedge clk);
    n_tests++; if ({Busy, HI, LO} !== 65'd0) begin n_fail++;
      $display("FAIL reset_mid_discard: got busy=%b hi=%h lo=%h, expected all 0", Busy, HI, LO); end
    m_hi = 32'd0; m_lo = 32'd0;
  endtask

`ifdef MDU_CANCEL_EN
  task automatic test_cancel;
    Start = 1'b1; MDOp = 3'd6; A = 32'h00000055;
    @(negedge clk); Start = 1'b0; MDOp = 3'd0;
    m_lo = 32'h00000055;
    launch(3'd3, 32'd100, 32'd7, 64'd0);
    @(negedge clk);
    Cancel = 1'b1;
    @(negedge clk); Cancel = 1'b0;
    void'(sb_q.pop_front());
    n_tests++; if ({Busy, HI, LO} !== {1'b0, m_hi, m_lo}) begin n_fail++;
      $display("FAIL cancel_run: got busy=%b hi=%h lo=%h, expected busy=0 hi=%h lo=%h", Busy, HI, LO, m_hi, m_lo); end
    repeat (DC + 2) @(negedge clk);
    n_tests++; if ({HI, LO} !== {m_hi, m_lo}) begin n_fail++;
      $display("FAIL cancel_discard: got hi=%h lo=%h, expected hi=%h lo=%h", HI, LO, m_hi, m_lo); end
    Start = 1'b1; MDOp = 3'd5; A = 32'h77777777; Cancel = 1'b1;
    @(negedge clk); Start = 1'b0; MDOp = 3'd0; Cancel = 1'b0;
    n_tests++; if (HI !== m_hi) begin n_fail++; $display("FAIL cancel_start: got %h, expected %h", HI, m_hi); end
  endtask
`endif

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_mthi_mtlo();
    test_ignore_while_busy();
    test_back_to_back();
    test_reset_mid();
`ifdef MDU_CANCEL_EN
    test_cancel();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time bound");
    $fatal(1);
  end

endmodule
